// File: rtl/a_mv_mac_pkg.sv
// a_mv_mac_pkg
// Shared types, constants and address helpers for the A-matrix
// matrix-vector MAC stage (a_mv_mac and its accumulator bank).
//   state_e        : controller states IDLE -> LOAD_X -> FETCH -> DRAIN -> OUT
//   N_ROWS/N_COLS  : shape of A (8 rows x 4 columns)
//   WORDS_PER_COL  : ROM words per column (two rows packed per word)
//   addr_col/addr_k: split a ROM address into column and row-pair index
package a_mv_mac_pkg;

   localparam int N_ROWS        = 8;
   localparam int N_COLS        = 4;
   localparam int WORDS_PER_COL = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_X = 3'd1,
      ST_FETCH  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_OUT    = 3'd4
   } state_e;

   // ROM address = col*4 + k
   function automatic logic [1:0] addr_col(input logic [3:0] addr);
      return addr[3:2];
   endfunction

   function automatic logic [1:0] addr_k(input logic [3:0] addr);
      return addr[1:0];
   endfunction

endpackage

// File: rtl/a_mv_mac_acc_bank.sv
// a_mv_acc_bank
// Eight unsigned accumulators for y = A*x. Each update adds two products
// (hi word half into row 2k, lo half into row 2k+1) for one column.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : clear all accumulators
//   en            : accumulate a_hi*x_col into acc[2k], a_lo*x_col into acc[2k+1]
//   a_hi, a_lo    : the two A elements of the current ROM word
//   x_col         : x element for the current column
//   k             : row-pair index of the current ROM word
//   rd_idx/rd_data: combinational read port of one accumulator
module a_mv_acc_bank
   import a_mv_mac_pkg::*;
#(
   parameter int AW = 7,
   parameter int XW = 8,
   parameter int YW = AW + XW + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [AW-1:0] a_hi,
   input  logic [AW-1:0] a_lo,
   input  logic [XW-1:0] x_col,
   input  logic [1:0]    k,
   input  logic [2:0]    rd_idx,
   output logic [YW-1:0] rd_data
);

   logic [YW-1:0]    acc_r [N_ROWS];
   logic [AW+XW-1:0] prod_hi_s;
   logic [AW+XW-1:0] prod_lo_s;
   logic [2:0]       row_even_s;
   logic [2:0]       row_odd_s;

   // Operands widened to the full product width so no bits are lost
   assign prod_hi_s  = {{XW{1'b0}}, a_hi} * {{AW{1'b0}}, x_col};
   assign prod_lo_s  = {{XW{1'b0}}, a_lo} * {{AW{1'b0}}, x_col};
   assign row_even_s = {k, 1'b0};
   assign row_odd_s  = {k, 1'b1};

   // Accumulator storage: clear on reset/clr, two-row update when enabled
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < N_ROWS; i++) begin
            acc_r[i] <= {YW{1'b0}};
         end
      end else if (en) begin
         acc_r[row_even_s] <= acc_r[row_even_s] + {{(YW-AW-XW){1'b0}}, prod_hi_s};
         acc_r[row_odd_s]  <= acc_r[row_odd_s]  + {{(YW-AW-XW){1'b0}}, prod_lo_s};
      end else begin
         for (int i = 0; i < N_ROWS; i++) begin
            acc_r[i] <= acc_r[i];
         end
      end
   end

   assign rd_data = acc_r[rd_idx];

endmodule

// File: rtl/a_mv_mac.sv
// a_mv_mac
// Sequences the A-matrix ROM, unpacks each word into two A elements and
// computes y = A*x (A 8x4 unsigned AW-bit, x 4 elements unsigned XW-bit).
//   clk, rst           : clock, synchronous active-high reset
//   start              : one-cycle pulse, honoured only in IDLE
//   x_data/x_valid/x_ready : x element stream, x[0]..x[3]
//   rom_addr, A_input  : ROM address out, ROM word in (one clock later)
//   res_data/res_idx/res_valid/res_ready : result stream y[0]..y[7]
//   busy               : high in every state except IDLE
// All outputs are registered; they are loaded from next-state values.
module a_mv_mac
   import a_mv_mac_pkg::*;
#(
   parameter int AW = 7,
   parameter int XW = 8,
   parameter int YW = AW + XW + 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XW-1:0]   x_data,
   input  logic            x_valid,
   output logic            x_ready,
   output logic [3:0]      rom_addr,
   input  logic [2*AW-1:0] A_input,
   output logic [YW-1:0]   res_data,
   output logic [2:0]      res_idx,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            busy
);

   state_e        state_r;
   state_e        state_nxt_s;
   logic [1:0]    cnt_r;
   logic [1:0]    cnt_nxt_s;
   logic [XW-1:0] x_r [N_COLS];
   logic          x_wr_s;
   logic          clr_s;
   logic [3:0]    rom_addr_r;     // also serves as the FETCH address counter
   logic [3:0]    rom_addr_nxt_s;
   logic          dvalid_r;       // A_input holds the word for daddr_r
   logic [3:0]    daddr_r;
   logic [2:0]    res_idx_r;      // also serves as the OUT row counter
   logic [2:0]    idx_nxt_s;
   logic [YW-1:0] rd_data_s;
   logic [YW-1:0] res_data_r;
   logic          x_ready_r;
   logic          res_valid_r;
   logic          busy_r;

   // Next-state and counter logic for the controller
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      rom_addr_nxt_s = 4'd0;
      idx_nxt_s      = res_idx_r;
      x_wr_s         = 1'b0;
      clr_s          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            idx_nxt_s = 3'd0;
            if (start) begin
               state_nxt_s = ST_LOAD_X;
               cnt_nxt_s   = 2'd0;
               clr_s       = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD_X: begin
            if (x_valid && x_ready_r) begin
               x_wr_s    = 1'b1;
               cnt_nxt_s = cnt_r + 2'd1;
               if (cnt_r == 2'd3) begin
                  state_nxt_s = ST_FETCH;
               end else begin
                  state_nxt_s = ST_LOAD_X;
               end
            end else begin
               state_nxt_s = ST_LOAD_X;
            end
         end
         ST_FETCH: begin
            if (rom_addr_r == 4'd15) begin
               state_nxt_s    = ST_DRAIN;
               rom_addr_nxt_s = 4'd0;
            end else begin
               state_nxt_s    = ST_FETCH;
               rom_addr_nxt_s = rom_addr_r + 4'd1;
            end
         end
         ST_DRAIN: begin
            // Rows 0/1 were last updated at address 12, so acc[0] is final
            // even though rows 6/7 are still being written this cycle.
            state_nxt_s = ST_OUT;
            idx_nxt_s   = 3'd0;
         end
         ST_OUT: begin
            if (res_valid_r && res_ready) begin
               if (res_idx_r == 3'd7) begin
                  state_nxt_s = ST_IDLE;
                  idx_nxt_s   = 3'd0;
               end else begin
                  state_nxt_s = ST_OUT;
                  idx_nxt_s   = res_idx_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 3'd0;
         end
      endcase
   end

   // Controller state, counters, x registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 2'd0;
         rom_addr_r  <= 4'd0;
         dvalid_r    <= 1'b0;
         daddr_r     <= 4'd0;
         res_idx_r   <= 3'd0;
         res_data_r  <= {YW{1'b0}};
         x_ready_r   <= 1'b0;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         for (int i = 0; i < N_COLS; i++) begin
            x_r[i] <= {XW{1'b0}};
         end
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         rom_addr_r  <= rom_addr_nxt_s;
         // ROM is registered: the word arrives one clock after its address
         dvalid_r    <= (state_r == ST_FETCH);
         daddr_r     <= rom_addr_r;
         res_idx_r   <= idx_nxt_s;
         res_data_r  <= (state_nxt_s == ST_OUT) ? rd_data_s : {YW{1'b0}};
         x_ready_r   <= (state_nxt_s == ST_LOAD_X);
         res_valid_r <= (state_nxt_s == ST_OUT);
         busy_r      <= (state_nxt_s != ST_IDLE);
         if (x_wr_s) begin
            x_r[cnt_r] <= x_data;
         end else begin
            x_r[cnt_r] <= x_r[cnt_r];
         end
      end
   end

   a_mv_acc_bank #(
      .AW (AW),
      .XW (XW),
      .YW (YW)
   ) u_acc_bank (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr_s),
      .en      (dvalid_r),
      .a_hi    (A_input[2*AW-1:AW]),
      .a_lo    (A_input[AW-1:0]),
      .x_col   (x_r[addr_col(daddr_r)]),
      .k       (addr_k(daddr_r)),
      .rd_idx  (idx_nxt_s),
      .rd_data (rd_data_s)
   );

   assign x_ready   = x_ready_r;
   assign rom_addr  = rom_addr_r;
   assign res_data  = res_data_r;
   assign res_idx   = res_idx_r;
   assign res_valid = res_valid_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_a_mv_mac.sv
// tb_a_mv_mac
// Self-checking bench for a_mv_mac: registered ROM model, reference
// y = A*x computed with plain integer arithmetic, directed and random runs.
module tb_a_mv_mac;

   localparam int AW = 7;
   localparam int XW = 8;
   localparam int YW = AW + XW + 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [XW-1:0]   x_data;
   logic            x_valid;
   logic            x_ready;
   logic [3:0]      rom_addr;
   logic [2*AW-1:0] A_input;
   logic [YW-1:0]   res_data;
   logic [2:0]      res_idx;
   logic            res_valid;
   logic            res_ready;
   logic            busy;

   always #5 clk = ~clk;

   a_mv_mac #(.AW(AW), .XW(XW), .YW(YW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .x_data    (x_data),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .rom_addr  (rom_addr),
      .A_input   (A_input),
      .res_data  (res_data),
      .res_idx   (res_idx),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy)
   );

   logic [2*AW-1:0] rom_q [16];
   int amat [8][4];
   int xvec [4];
   int y_exp [8];
   int n_checks = 0;
   int n_fail   = 0;

   // Registered ROM model
   always @(posedge clk) A_input <= rom_q[rom_addr];

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic load_rom();
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++)
            rom_q[c*4+k] = {AW'(amat[2*k][c]), AW'(amat[2*k+1][c])};
   endtask

   task automatic plan_matrix();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++)
            amat[r][c] = (c == 0) ? r + 1 : 1;
      load_rom();
   endtask

   task automatic set_x(input int a, input int b, input int c, input int d);
      xvec[0] = a; xvec[1] = b; xvec[2] = c; xvec[3] = d;
   endtask

   // x_mode/r_mode: 0 = always valid/ready, 1 = plan pattern, 2 = random
   task automatic run_mac(input int x_mode, input int r_mode, input bit spur);
      int addr_q[$];
      int xi, got, cyc, stall_n, pdata, pidx, extra, first, nz, bad;
      bit stalled, rdy;
      for (int i = 0; i < 8; i++) begin
         y_exp[i] = 0;
         for (int c = 0; c < 4; c++) y_exp[i] += amat[i][c] * xvec[c];
      end
      xi = 0; got = 0; cyc = 0; stall_n = 0; stalled = 1'b0; pdata = 0; pidx = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check_val("busy_after_start", int'(busy), 1);
      while (got < 8 && cyc < 2000) begin
         start = 1'b0;
         addr_q.push_back(int'(rom_addr));
         if (stalled) begin
            check_val("stall_valid", int'(res_valid), 1);
            check_val("stall_data", int'(res_data), pdata);
            check_val("stall_idx", int'(res_idx), pidx);
         end
         // x side
         if (xi < 4) begin
            case (x_mode)
               0:       x_valid = 1'b1;
               1:       x_valid = (cyc % 2 == 0);
               default: x_valid = ($urandom_range(0, 2) != 0);
            endcase
            x_data = XW'(xvec[xi]);
            if (x_valid && x_ready) xi++;
         end else begin
            x_valid = 1'b0;
         end
         // spurious starts in FETCH and in OUT
         if (spur && (rom_addr == 4'd5 || (res_valid && got == 2))) start = 1'b1;
         // result side
         case (r_mode)
            0: rdy = 1'b1;
            1: begin
               if (res_valid && res_idx == 3'd3 && stall_n < 5) begin
                  rdy = 1'b0;
                  stall_n++;
               end else begin
                  rdy = 1'b1;
               end
            end
            default: rdy = ($urandom_range(0, 2) != 0);
         endcase
         res_ready = rdy;
         stalled = res_valid && !rdy;
         pdata = int'(res_data);
         pidx  = int'(res_idx);
         if (res_valid && rdy) begin
            check_val("res_idx", int'(res_idx), got);
            check_val("res_data", int'(res_data), y_exp[got]);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; x_valid = 1'b0; res_ready = 1'b0;
      check_val("result_count", got, 8);
      if (x_mode == 0 && r_mode == 0) check_val("latency", cyc, 29);
      check_val("valid_drop", int'(res_valid), 0);
      check_val("busy_drop", int'(busy), 0);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (res_valid || busy) extra++;
      end
      check_val("single_burst", extra, 0);
      // rom_addr must sweep 0..15 once on consecutive cycles
      first = -1; nz = 0; bad = 0;
      foreach (addr_q[i]) begin
         if (addr_q[i] != 0) nz++;
         if (addr_q[i] == 1 && first < 0) first = i;
      end
      if (first < 1 || first + 15 >= addr_q.size()) begin
         bad = 1;
      end else begin
         for (int j = 0; j <= 16; j++)
            if (addr_q[first-1+j] != (j % 16)) bad++;
      end
      check_val("rom_sweep_bad", bad, 0);
      check_val("rom_nonzero", nz, 15);
   endtask

   task automatic reset_mid_run();
      int w;
      set_x(1, 1, 1, 1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      x_valid = 1'b1; x_data = XW'(1); res_ready = 1'b1;
      w = 0;
      while (rom_addr != 4'd9 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check_val("wait_addr9", int'(rom_addr), 9);
      rst = 1'b1; x_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_valid", int'(res_valid), 0);
      check_val("rst_addr", int'(rom_addr), 0);
      check_val("rst_xready", int'(x_ready), 0);
      @(negedge clk);
      check_val("rst_idle", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; x_data = '0; x_valid = 1'b0; res_ready = 1'b0;
      plan_matrix();
      repeat (3) @(negedge clk);
      check_val("reset_x_ready", int'(x_ready), 0);
      check_val("reset_rom_addr", int'(rom_addr), 0);
      check_val("reset_res_data", int'(res_data), 0);
      check_val("reset_res_idx", int'(res_idx), 0);
      check_val("reset_res_valid", int'(res_valid), 0);
      check_val("reset_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_busy", int'(busy), 0);

      set_x(1, 1, 1, 1);         run_mac(0, 0, 1'b0);   // basic
      set_x(2, 0, 0, 0);         run_mac(0, 0, 1'b0);   // column 0 only
      set_x(0, 3, 0, 0);         run_mac(0, 0, 1'b0);   // column 1, cleared acc
      set_x(255, 255, 255, 255); run_mac(0, 0, 1'b0);   // max values
      set_x(1, 1, 1, 1);         run_mac(1, 1, 1'b0);   // handshake stress
      reset_mid_run();
      set_x(1, 1, 1, 1);         run_mac(0, 0, 1'b0);   // clean run after reset
      set_x(1, 1, 1, 1);         run_mac(0, 0, 1'b1);   // spurious starts

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++)
            for (int c = 0; c < 4; c++)
               amat[i][c] = int'($urandom_range(0, 127));
         for (int c = 0; c < 4; c++) xvec[c] = int'($urandom_range(0, 255));
         load_rom();
         run_mac(2, 2, r[0]);
      end
      // worst case: every element at its maximum
      for (int i = 0; i < 8; i++)
         for (int c = 0; c < 4; c++)
            amat[i][c] = 127;
      load_rom();
      set_x(255, 255, 255, 255); run_mac(2, 2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
